// File: rtl/if_pkg.sv
// Shared constants for the instruction-fetch prefetch unit.
//   - default reset / interrupt / exception vectors and the NOP instruction
//   - bit positions inside select_PC_next and status
package if_pkg;

    localparam logic [31:0] IF_RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] IF_ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] IF_XADR_VEC  = 32'h8000_0008;
    localparam logic [31:0] IF_NOP_INSTR = 32'h0000_0000;

    // select_PC_next = {Z, J, JR}
    localparam int unsigned SEL_Z  = 2;
    localparam int unsigned SEL_J  = 1;
    localparam int unsigned SEL_JR = 0;

    // status = {interrupt, exception}
    localparam int unsigned ST_INT = 1;
    localparam int unsigned ST_EXC = 0;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {PC+4, instruction} pairs.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i          enqueue wdata_i (accepted when not full, or full with pop_i)
//   pop_i           dequeue the head (ignored when empty)
//   flush_i         drop all entries; overrides push/pop
//   wdata_i         entry to enqueue
//   rdata_o         head entry, straight from storage
//   full_o/empty_o  occupancy flags
//   count_o         occupied entries, 0..DEPTH
module fetch_queue
    import if_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // When full, a push is only legal alongside a pop: the write lands in the
    // slot being vacated, whose old contents are read out this same cycle.
    assign do_push = push_i & (~full_o | pop_i) & ~flush_i;
    assign do_pop  = pop_i & ~empty_o & ~flush_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PW'(1);
            if (do_pop)  rptr_d = rptr_q + PW'(1);
            count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the head is only exposed while count is non-zero.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage with a prefetch queue.
// Generates the PC, fetches from a combinational ROM port, buffers
// {PC+4, instruction} pairs and hands them to ID over valid/ready.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_addr / imem_rdata     fetch address (current PC) and same-cycle data
//   id_ready                   ID accepts the head this cycle
//   if_id_valid/instr/pc4      head entry (NOP_INSTR / 0 when not valid)
//   branch/jump/jr_target      redirect targets from ID
//   select_PC_next             {Z, J, JR} redirect requests
//   status                     {interrupt, exception}
//   queue_count                occupied queue entries
module if_prefetch_unit
    import if_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [DATA_W-1:0] RESET_VEC = DATA_W'(IF_RESET_VEC),
    parameter logic [DATA_W-1:0] ILLOP_VEC = DATA_W'(IF_ILLOP_VEC),
    parameter logic [DATA_W-1:0] XADR_VEC  = DATA_W'(IF_XADR_VEC),
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(IF_NOP_INSTR)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [DATA_W-1:0]      imem_addr,
    input  logic [DATA_W-1:0]      imem_rdata,
    input  logic                   id_ready,
    output logic                   if_id_valid,
    output logic [DATA_W-1:0]      if_id_instr,
    output logic [DATA_W-1:0]      if_id_pc4,
    input  logic [DATA_W-1:0]      branch_target,
    input  logic [DATA_W-1:0]      jump_target,
    input  logic [DATA_W-1:0]      jr_target,
    input  logic [2:0]             select_PC_next,
    input  logic [1:0]             status,
    output logic [$clog2(DEPTH):0] queue_count
);

    logic [DATA_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   pc4;
    logic                exc_req, int_req, redirect;
    logic [DATA_W-1:0]   redirect_pc;
    logic                push, pop, q_full, q_empty;
    logic [2*DATA_W-1:0] q_head;

    assign pc4       = pc_q + DATA_W'(4);
    assign imem_addr = pc_q;

    // Interrupts are masked in kernel mode (PC MSB set); exceptions never are.
    assign exc_req  = status[ST_EXC];
    assign int_req  = status[ST_INT] & ~pc_q[DATA_W-1];
    assign redirect = exc_req | int_req | (|select_PC_next);

    always_comb begin
        redirect_pc = pc_q;
        if (exc_req)                     redirect_pc = XADR_VEC;
        else if (int_req)                redirect_pc = ILLOP_VEC;
        else if (select_PC_next[SEL_JR]) redirect_pc = jr_target;
        else if (select_PC_next[SEL_J])  redirect_pc = jump_target;
        else if (select_PC_next[SEL_Z])  redirect_pc = branch_target;
    end

    // A redirect flushes everything, including the head, so no pop is issued.
    assign pop  = if_id_valid & id_ready & ~redirect;
    assign push = ~redirect & (~q_full | pop);

    always_comb begin
        pc_d = pc_q;
        if (redirect)  pc_d = redirect_pc;
        else if (push) pc_d = pc4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_VEC;
        else        pc_q <= pc_d;
    end

    fetch_queue #(
        .WIDTH (2*DATA_W),
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect),
        .wdata_i ({pc4, imem_rdata}),
        .rdata_o (q_head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (queue_count)
    );

    assign if_id_valid = ~q_empty;
    assign if_id_instr = q_empty ? NOP_INSTR : q_head[DATA_W-1:0];
    assign if_id_pc4   = q_empty ? '0 : q_head[2*DATA_W-1:DATA_W];

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
- Parametrised successor to the single-register IF stage.
- Generates the PC and fetches from a combinational instruction ROM port.
- Buffers fetched {PC+4, instruction} pairs in a DEPTH-entry prefetch queue, so fetch continues while ID stalls.
- Feeds ID through a valid/ready handshake. Handles branch/jump/jr redirects and interrupt/exception vectoring with a full queue flush.

Parameters:
- DATA_W, 32, instruction and PC width.
- DEPTH, 4, prefetch queue entries; power of 2, >= 2.
- RESET_VEC, 32'h8000_0000, PC after reset.
- ILLOP_VEC, 32'h8000_0004, interrupt target.
- XADR_VEC, 32'h8000_0008, exception target.
- NOP_INSTR, 32'h0000_0000, instruction presented when the queue is empty.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- imem_addr  out  DATA_W  fetch address (current PC).
- imem_rdata  in  DATA_W  instruction at imem_addr, same cycle.
- id_ready  in  1  ID accepts the head entry this cycle.
- if_id_valid  out  1  head entry is valid.
- if_id_instr  out  DATA_W  head instruction (NOP_INSTR when not valid).
- if_id_pc4  out  DATA_W  head PC+4 (0 when not valid).
- branch_target  in  DATA_W  taken-branch target.
- jump_target  in  DATA_W  J/JAL target.
- jr_target  in  DATA_W  JR/JALR target.
- select_PC_next  in  3  {Z, J, JR} redirect requests from ID.
- status  in  2  {interrupt, exception}.
- queue_count  out  $clog2(DEPTH)+1  occupied entries (debug/perf).

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_VEC, queue empty, if_id_valid=0.
  - if_id_instr=NOP_INSTR, if_id_pc4=0, queue_count=0.
  - imem_addr follows PC, so it reads RESET_VEC.
- Redirect priority (highest first): exception -> XADR_VEC; interrupt -> ILLOP_VEC; JR -> jr_target; J -> jump_target; Z -> branch_target.
- Interrupt masking: interrupt is ignored while PC[DATA_W-1]=1 (kernel mode). Exception is never masked.
- Redirect active (any unmasked request) at edge t:
  - queue flushed (count=0); PC=target.
  - The fetch at cycle t is discarded and the head is not counted as a separate pop.
  - Cycle t+1: if_id_valid=0 and target is fetched. Cycle t+2: target instruction at head.
- No redirect:
  - pop = if_id_valid & id_ready.
  - push = (count<DEPTH) | pop.
  - On push: enqueue {PC+4, imem_rdata} and PC<=PC+4. Otherwise PC holds.
- Full queue with simultaneous pop: push and pop both occur, count unchanged.
- Fetch-to-head latency: 1 cycle when the queue is empty.
- Head outputs:
  - Driven combinationally from registered queue storage; no combinational path from id_ready to outputs.
  - Stable while valid & ~id_ready.
- Pointer and arithmetic rules:
  - Read/write pointers are $clog2(DEPTH) bits, wrap modulo DEPTH.
  - count is tracked separately, 0..DEPTH.
  - PC+4 wraps modulo 2^DATA_W.
- Reset asserted mid-stream: immediate return to reset values; no partial state survives.

Decomposition:
- Shared package if_pkg holds RESET_VEC/ILLOP_VEC/XADR_VEC defaults, NOP_INSTR, and redirect-select bit positions (SEL_Z=2, SEL_J=1, SEL_JR=0; ST_INT=1, ST_EXC=0).
- One sub-module: fetch_queue.
  - Synchronous FIFO: push/pop/flush, full/empty, count.
  - Parametrised WIDTH=2*DATA_W and DEPTH.
- The PC register and redirect mux stay in if_prefetch_unit.

Test Plan:
- Reset then id_ready=1, no redirects -> imem_addr 80000000, 80000004, 80000008 on consecutive cycles; head pc4 80000004 valid from cycle 1, one pop per cycle.
- Hold id_ready=0 from reset -> count rises 0..4; PC freezes at 80000010; head stays pc4=80000004.
- Release id_ready with the queue full -> push and pop together, count stays 4 until ready drops.
- Queue at 3 entries, select_PC_next=3'b100, branch_target=00000040 -> next cycle count=0, valid=0, imem_addr=00000040; following cycle head pc4=00000044.
- status=2'b01 with select_PC_next=3'b001 (jr_target=00000100) -> PC=80000008 (exception wins).
- PC=80000020, status=2'b10 -> no redirect, streaming continues. Same with PC=00000020 -> PC=80000004, queue flushed.
- Reset pulse while queue holds 2 entries -> valid=0, count=0, if_id_instr=0 asynchronously; after release imem_addr=80000000.
